softmax_stream: RTL

SOFTMAX_STREAM -- requirements
Module: softmax_stream

---
 rtl/softmax_stream.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/softmax_stream.sv
// rtl/softmax_stream.sv - streaming base-2 softmax over one node's neighbour coefficients
//
// Purpose: buffers up to N_MAX signed coefficients per node, converts each one to a
// power-of-two exponential term (optionally relative to the running max), sums the
// terms, then emits alpha_k = floor(exp_k * 2^OUT_F / sum) one element at a time.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   clr                     synchronous abort back to IDLE (clears ovf_err)
//   in_valid/in_ready       coefficient handshake; in_coef signed, in_last ends the node
//   out_valid/out_ready     alpha handshake; out_alpha = alpha * 2^OUT_F, out_idx, out_last
//   num_nodes_o             coefficient count of the node being processed
//   busy                    FSM is outside IDLE
//   ovf_err                 sticky: a node hit N_MAX beats without in_last
module softmax_stream #(
    parameter int N_MAX   = 16,
    parameter int COEF_W  = 8,
    parameter int EXP_W   = 16,
    parameter int OUT_F   = 8,
    parameter int MAX_SUB = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [COEF_W-1:0]           in_coef,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_F:0]              out_alpha,
    output logic [$clog2(N_MAX)-1:0]    out_idx,
    output logic                        out_last,
    output logic [$clog2(N_MAX+1)-1:0]  num_nodes_o,
    output logic                        busy,
    output logic                        ovf_err
);
    localparam int IDX_W  = $clog2(N_MAX);
    localparam int CNT_W  = $clog2(N_MAX + 1);
    localparam int SUM_W  = EXP_W + $clog2(N_MAX);
    localparam int BUF_W  = (COEF_W > EXP_W) ? COEF_W : EXP_W;
    localparam int DCNT_W = $clog2(OUT_F + 1);
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_EXP, S_DIV, S_OUT} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [COEF_W-1:0]  max_q, max_d;
    logic [SUM_W-1:0]          sum_q, sum_d;
    logic [IDX_W-1:0]          k_q, k_d;
    logic [SUM_W:0]            rem_q, rem_d;
    logic [OUT_F:0]            quo_q, quo_d;
    logic [DCNT_W-1:0]         dcnt_q, dcnt_d;
    logic                      ovf_q, ovf_d;
    logic [BUF_W-1:0]          buf_q [N_MAX];
    logic [BUF_W-1:0]          buf_d [N_MAX];

    logic                      accept;
    logic                      last_k;
    logic signed [COEF_W-1:0]  cur_coef;
    logic [COEF_W:0]           diff;
    logic [EXP_W-1:0]          exp_cur;
    logic [SUM_W:0]            rem_sub;
    logic                      q_bit;

    assign in_ready    = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept      = in_valid && in_ready;
    assign last_k      = (CNT_W'(k_q) + CNT_W'(1)) == count_q;
    assign cur_coef    = buf_q[k_q][COEF_W-1:0];
    assign out_valid   = (state_q == S_OUT);
    assign out_alpha   = out_valid ? quo_q : '0;
    assign out_idx     = k_q;
    assign out_last    = out_valid && last_k;
    assign num_nodes_o = count_q;
    assign busy        = (state_q != S_IDLE);
    assign ovf_err     = ovf_q;

    // Exponential term of the element at k_q. In max-subtract mode the max
    // element maps to 2^(EXP_W-1), so the sum can never be zero.
    always_comb begin
        diff    = '0;
        exp_cur = '0;
        if (MAX_SUB != 0) begin
            // max_q >= cur_coef, so the two's-complement difference is non-negative
            diff = {max_q[COEF_W-1], max_q} - {cur_coef[COEF_W-1], cur_coef};
            if (int'(diff) <= EXP_W - 1) begin
                exp_cur = EXP_ONE << (EXP_W - 1 - int'(diff));
            end
        end else begin
            if (cur_coef <= 0) begin
                exp_cur = EXP_ONE;
            end else if (int'(cur_coef) >= EXP_W - 1) begin
                exp_cur = EXP_ONE << (EXP_W - 1);
            end else begin
                exp_cur = EXP_ONE << int'(cur_coef);
            end
        end
    end

    // Restoring divider step. The remainder starts at exp_k (<= sum), so the first
    // step yields the 2^OUT_F quotient bit and OUT_F+1 steps cover the full result.
    always_comb begin
        rem_sub = rem_q;
        q_bit   = 1'b0;
        if (rem_q >= {1'b0, sum_q}) begin
            rem_sub = rem_q - {1'b0, sum_q};
            q_bit   = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        max_d   = max_q;
        sum_d   = sum_q;
        k_d     = k_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dcnt_d  = dcnt_q;
        ovf_d   = ovf_q;
        buf_d   = buf_q;
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (accept) begin
                    buf_d[count_q[IDX_W-1:0]] = BUF_W'($signed(in_coef));
                    count_d = count_q + CNT_W'(1);
                    if (count_q == '0 || $signed(in_coef) > max_q) begin
                        max_d = $signed(in_coef);
                    end
                    if (count_q == '0) begin
                        sum_d = '0;
                    end
                    if (in_last || count_q == CNT_W'(N_MAX - 1)) begin
                        state_d = S_EXP;
                        // walk the buffer downwards so element 0 is the last one
                        // converted and can seed the divider directly
                        k_d     = count_q[IDX_W-1:0];
                        if (!in_last) begin
                            ovf_d = 1'b1;
                        end
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_EXP: begin
                buf_d[k_q] = BUF_W'(exp_cur);
                sum_d      = sum_q + SUM_W'(exp_cur);
                if (k_q == '0) begin
                    state_d = S_DIV;
                    rem_d   = (SUM_W + 1)'(exp_cur);
                    dcnt_d  = '0;
                end else begin
                    k_d = k_q - IDX_W'(1);
                end
            end
            S_DIV: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[OUT_F-1:0], q_bit};
                if (dcnt_q == DCNT_W'(OUT_F)) begin
                    state_d = S_OUT;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    if (last_k) begin
                        state_d = S_IDLE;
                        count_d = '0;
                        sum_d   = '0;
                        k_d     = '0;
                    end else begin
                        state_d = S_DIV;
                        k_d     = k_q + IDX_W'(1);
                        rem_d   = (SUM_W + 1)'(buf_q[k_q + IDX_W'(1)][EXP_W-1:0]);
                        dcnt_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
            count_d = '0;
            sum_d   = '0;
            k_d     = '0;
            ovf_d   = 1'b0;
            buf_d   = buf_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            max_q   <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dcnt_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i < N_MAX; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dcnt_q  <= dcnt_d;
            ovf_q   <= ovf_d;
            buf_q   <= buf_d;
        end
    end
endmodule
